queue_calc: RTL and testbench
=============================

# queue_calc

Parametrised queue calculator that merges the operand queue and ALU into one synchronous block with a valid/ready command handshake. Operands are pushed to the back of a circular queue. A CALC command pops the two oldest entries, applies the selected ALU operation and pushes the result back to the tail. It is the next generation of the queue/ALU pair: one clock domain, configurable width and depth, and explicit error reporting.

## Interface
- WIDTH, 8, data width of queue entries and result
- DEPTH, 8, queue entries; power of two, ≥ 2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0 NOP, 1 PUSH, 2 POP, 3 CALC
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SHL, 7 SHR; sampled with CALC
- push_val  in  WIDTH  data for PUSH
- result  out  WIDTH  last POP or CALC value
- result_valid  out  1  one-cycle pulse when result updates
- carry  out  1  carry/borrow of the last ADD/SUB, else 0
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH / count==0
- err  out  1  one-cycle pulse on a rejected command

## Operation
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready=1 only in state IDLE. The bench holds cmd_valid and data until accepted.
- FSM states: IDLE, EXEC, WRITE.
  - IDLE: handles NOP, PUSH and POP in a single cycle. An accepted CALC goes to EXEC.
  - EXEC: registers a=head and b=head+1 (wrapped) and latches alu_op. Goes to WRITE.
  - WRITE: registers the ALU output into result, pops 2, pushes 1, pulses result_valid. Goes to IDLE.
- PUSH: writes push_val at the tail and increments tail (mod DEPTH). If full: rejected, err pulses, queue unchanged.
- POP: result=head entry, head increments, result_valid pulses. If empty: rejected, err pulses, result is held.
- CALC with count<2: rejected in IDLE (no EXEC), err pulses. CALC with the queue full is legal; net occupancy change is −1.
- ALU operations (a = older entry):
  - ADD and SUB are modulo 2^WIDTH. carry = bit WIDTH of a+b, or borrow (a<b) for SUB.
  - MUL returns the low WIDTH bits.
  - SHL/SHR shift a by b[$clog2(WIDTH)-1:0] and zero-fill.
- The NOP handshake completes with no effect.
- Pointers wrap at DEPTH. count is a separate counter, not derived from the pointers.

## Timing
- Reset values (async, immediate): head=tail=0, count=0, empty=1, full=0, cmd_ready=1, result=0, result_valid=0, carry=0, err=0, state=IDLE. Queue storage is not cleared.
- PUSH/POP: count, full and empty update on the edge after acceptance. For POP, result_valid is high during the cycle after acceptance.
- CALC: accepted at edge N, EXEC at N+1, WRITE completes at N+2. result_valid is high during the cycle after edge N+2. cmd_ready is low for 2 cycles.
- err is high for the cycle after the rejecting edge and is never asserted together with result_valid.
- rst asserted during EXEC/WRITE aborts the CALC: no partial pop, no result_valid.

## Configuration
- QUEUE_CALC_MUL_EN defined: a multiplier is instantiated and alu_op 5 returns a*b truncated to WIDTH.
- QUEUE_CALC_MUL_EN undefined: no multiplier. A CALC with alu_op 5 is rejected in IDLE with an err pulse, and the queue is unchanged.

## Structure
- Package queue_calc_pkg holds:
  - cmd_op encodings (CMD_NOP/PUSH/POP/CALC)
  - alu_op encodings (ALU_ADD…ALU_SHR)
  - FSM state enum (ST_IDLE/EXEC/WRITE)
- Sub-module queue_calc_alu: combinational, WIDTH-parametrised, inputs a, b, op; outputs y and carry. The MUL branch is guarded by the macro. The queue storage, pointers and FSM stay in the top.

## Test plan
- Reset, then PUSH 1, 2, 3, 4 (WIDTH=8, DEPTH=8) → count=4, empty=0, no err.
- From the previous state, CALC with ALU_SUB → after 2 busy cycles, result=0xFF (1−2), carry=1, count=3, queue holds 3, 4, 0xFF.
- PUSH 0x80, 0x80, then CALC with ALU_ADD on an otherwise empty queue → result=0x00, carry=1, count=1.
- Fill to 8 entries, then PUSH 9 → err pulse, count stays 8; CALC with ALU_XOR → count=7; POP on an empty queue → err, result unchanged.
- With the macro undefined, push 3 and 5, then CALC with ALU_MUL → err pulse, count=2. With the macro defined → result=15.
- Assert rst one cycle after CALC acceptance → all outputs at reset values, no result_valid.

Source files
------------

// File: rtl/queue_calc_pkg.sv
// queue_calc_pkg: shared encodings for the queue calculator.
// Holds the command and ALU opcode encodings, the control FSM state
// enum and a helper that reports which ALU opcodes the current build
// supports (MUL depends on QUEUE_CALC_MUL_EN).
package queue_calc_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2,
    CMD_CALC = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MUL = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // True when the build can execute the given ALU opcode.
  function automatic logic alu_op_supported(input logic [2:0] op);
`ifdef QUEUE_CALC_MUL_EN
    return (op == op);
`else
    return (op != ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/queue_calc_alu.sv
// queue_calc_alu: combinational WIDTH-bit ALU for the queue calculator.
// a is the older queue entry, b the newer one. carry is the carry out
// of ADD or the borrow (a < b) of SUB, and 0 for every other opcode.
// The multiplier exists only when QUEUE_CALC_MUL_EN is defined; without
// it the MUL opcode yields 0 (the top never issues it in that build).
module queue_calc_alu
  import queue_calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  // Shift amount width; a 1-bit datapath still gets a 1-bit amount.
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [SW-1:0]  sh;

  // Select the operation result and its carry/borrow flag.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    sh    = b[SW-1:0];
    y     = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      ALU_SUB: begin
        y     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_MUL: begin
`ifdef QUEUE_CALC_MUL_EN
        y = a * b;
`else
        y = '0;
`endif
      end
      ALU_SHL: y = a << sh;
      ALU_SHR: y = a >> sh;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/queue_calc.sv
// queue_calc: circular operand queue with an attached ALU.
// Build option: define QUEUE_CALC_MUL_EN to enable the multiplier
// (alu_op 5); otherwise a CALC with alu_op 5 is rejected with err.
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready is high only in ST_IDLE; the source
// keeps cmd_valid, cmd_op, alu_op and push_val stable until the transfer.
// Every transferred command either takes effect or is rejected with a
// one-cycle err pulse; err and result_valid never pulse together.
//
// PUSH/POP/NOP complete in IDLE. CALC walks IDLE -> EXEC (operands
// registered) -> WRITE (result stored, two popped, one pushed) -> IDLE.
module queue_calc
  import queue_calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [2:0]              alu_op,
  input  logic [WIDTH-1:0]        push_val,
  output logic [WIDTH-1:0]        result,
  output logic                    result_valid,
  output logic                    carry,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    err,
  output logic [1:0]              state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  queue_calc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

  // Next-state, pointer, counter and output computation for the FSM.
  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    carry_d        = carry_q;
    err_d          = 1'b0;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    mem_we         = 1'b0;
    mem_waddr      = tail_q;
    mem_wdata      = push_val;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            CMD_PUSH: begin
              if (is_full) begin
                err_d = 1'b1;
              end else begin
                mem_we  = 1'b1;
                tail_d  = tail_q + PW'(1);
                count_d = count_q + CW'(1);
              end
            end
            CMD_POP: begin
              if (is_empty) begin
                err_d = 1'b1;
              end else begin
                result_d       = mem_q[head_q];
                result_valid_d = 1'b1;
                head_d         = head_q + PW'(1);
                count_d        = count_q - CW'(1);
              end
            end
            CMD_CALC: begin
              if ((count_q < CW'(2)) || !alu_op_supported(alu_op)) begin
                err_d = 1'b1;
              end else begin
                // alu_op is captured at the transfer edge because the
                // source may change it once the command has been taken.
                op_d    = alu_op;
                state_d = ST_EXEC;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        a_d     = mem_q[head_q];
        b_d     = mem_q[head_q + PW'(1)];
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // When the queue was full the tail slot equals the old head slot,
        // which is consumed in this same step, so overwriting it is safe.
        result_d       = alu_y;
        carry_d        = alu_carry;
        result_valid_d = 1'b1;
        mem_we         = 1'b1;
        mem_wdata      = alu_y;
        head_d         = head_q + PW'(2);
        tail_d         = tail_q + PW'(1);
        count_d        = count_q - CW'(1);
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      carry_q        <= 1'b0;
      err_q          <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      carry_q        <= carry_d;
      err_q          <= err_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
    end
  end

  // Queue storage; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign carry        = carry_q;
  assign count        = count_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign err          = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_queue_calc.sv
// tb_queue_calc: directed bench for queue_calc (WIDTH=8, DEPTH=8).
// Expected values are hand-computed for each vector.
module tb_queue_calc;
  import queue_calc_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] alu_op;
  logic [7:0] push_val;
  logic [7:0] result;
  logic       result_valid;
  logic       carry;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       err;
  logic [1:0] state_dbg;

  int n_vec;
  int n_err;

  queue_calc #(.WIDTH(8), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .alu_op       (alu_op),
    .push_val     (push_val),
    .result       (result),
    .result_valid (result_valid),
    .carry        (carry),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    alu_op    = 3'd0;
    push_val  = 8'd0;
  end

  // Driver: present a command and hold it until transferred. Returns
  // 1 ns after the transfer edge.
  task automatic send(input logic [1:0] op, input logic [2:0] aop, input logic [7:0] val);
    bit done;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    alu_op    = aop;
    push_val  = val;
    for (int i = 0; i < 8 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      $display("FAIL send_timeout: cmd_ready=%0b required=1", cmd_ready);
      n_err++;
    end
    n_vec++;
  endtask

  // Driver: wait for a CALC to complete (bounded).
  task automatic wait_result();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) seen = 1'b1;
    end
    if (!seen) begin
      $display("FAIL calc_timeout: result_valid=%0b required=1", result_valid);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset();
    #2;
    if ({count, empty, full, cmd_ready, result, result_valid, carry, err, state_dbg} !==
        {4'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      $display("FAIL reset_values: count=%0d empty=%0b full=%0b ready=%0b result=%h rv=%0b carry=%0b err=%0b st=%0d required 0 1 0 1 00 0 0 0 0",
               count, empty, full, cmd_ready, result, result_valid, carry, err, state_dbg);
      n_err++;
    end
    n_vec++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_push();
    for (int i = 1; i <= 4; i++) begin
      send(CMD_PUSH, 3'd0, 8'(i));
      if (count !== 4'(i) || err !== 1'b0 || empty !== 1'b0) begin
        $display("FAIL push_count: count=%0d err=%0b empty=%0b required %0d 0 0", count, err, empty, i);
        n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_calc_sub();
    logic [7:0] exp_q[$];
    send(CMD_CALC, ALU_SUB, 8'd0);
    if (cmd_ready !== 1'b0 || state_dbg !== 2'd1) begin
      $display("FAIL sub_busy1: ready=%0b st=%0d required 0 1", cmd_ready, state_dbg);
      n_err++;
    end
    n_vec++;
    @(posedge clk); #1;
    if (cmd_ready !== 1'b0 || state_dbg !== 2'd2 || result_valid !== 1'b0) begin
      $display("FAIL sub_busy2: ready=%0b st=%0d rv=%0b required 0 2 0", cmd_ready, state_dbg, result_valid);
      n_err++;
    end
    n_vec++;
    @(posedge clk); #1;
    if (result_valid !== 1'b1 || result !== 8'hFF || carry !== 1'b1 || count !== 4'd3 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      $display("FAIL sub_result: rv=%0b result=%h carry=%0b count=%0d ready=%0b err=%0b required 1 ff 1 3 1 0",
               result_valid, result, carry, count, cmd_ready, err);
      n_err++;
    end
    n_vec++;
    @(posedge clk); #1;
    if (result_valid !== 1'b0) begin
      $display("FAIL sub_rv_pulse: rv=%0b required 0", result_valid);
      n_err++;
    end
    n_vec++;
    exp_q = '{8'h03, 8'h04, 8'hFF};
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      send(CMD_POP, 3'd0, 8'd0);
      if (result !== e || result_valid !== 1'b1) begin
        $display("FAIL sub_drain: result=%h rv=%0b required %h 1", result, result_valid, e);
        n_err++;
      end
      n_vec++;
    end
    if (empty !== 1'b1 || count !== 4'd0) begin
      $display("FAIL sub_empty: empty=%0b count=%0d required 1 0", empty, count);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_add_carry();
    send(CMD_PUSH, 3'd0, 8'h80);
    send(CMD_PUSH, 3'd0, 8'h80);
    send(CMD_CALC, ALU_ADD, 8'd0);
    wait_result();
    if (result !== 8'h00 || carry !== 1'b1 || count !== 4'd1) begin
      $display("FAIL add_carry: result=%h carry=%0b count=%0d required 00 1 1", result, carry, count);
      n_err++;
    end
    n_vec++;
    send(CMD_POP, 3'd0, 8'd0);
    if (result !== 8'h00 || empty !== 1'b1) begin
      $display("FAIL add_pop: result=%h empty=%0b required 00 1", result, empty);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_full();
    logic [7:0] exp_q[$];
    for (int i = 1; i <= 8; i++) send(CMD_PUSH, 3'd0, 8'(i));
    if (full !== 1'b1 || count !== 4'd8) begin
      $display("FAIL fill: full=%0b count=%0d required 1 8", full, count);
      n_err++;
    end
    n_vec++;
    send(CMD_PUSH, 3'd0, 8'd9);
    if (err !== 1'b1 || count !== 4'd8 || result_valid !== 1'b0) begin
      $display("FAIL push_full: err=%0b count=%0d rv=%0b required 1 8 0", err, count, result_valid);
      n_err++;
    end
    n_vec++;
    @(posedge clk); #1;
    if (err !== 1'b0) begin
      $display("FAIL err_pulse: err=%0b required 0", err);
      n_err++;
    end
    n_vec++;
    send(CMD_CALC, ALU_XOR, 8'd0);
    wait_result();
    if (result !== 8'h03 || carry !== 1'b0 || count !== 4'd7 || full !== 1'b0 || err !== 1'b0) begin
      $display("FAIL xor_full: result=%h carry=%0b count=%0d full=%0b err=%0b required 03 0 7 0 0",
               result, carry, count, full, err);
      n_err++;
    end
    n_vec++;
    exp_q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h03};
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      send(CMD_POP, 3'd0, 8'd0);
      if (result !== e) begin
        $display("FAIL full_drain: result=%h required %h", result, e);
        n_err++;
      end
      n_vec++;
    end
    send(CMD_POP, 3'd0, 8'd0);
    if (err !== 1'b1 || result_valid !== 1'b0 || result !== 8'h03 || count !== 4'd0) begin
      $display("FAIL pop_empty: err=%0b rv=%0b result=%h count=%0d required 1 0 03 0", err, result_valid, result, count);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_logic_shift();
    send(CMD_PUSH, 3'd0, 8'hF0);
    send(CMD_PUSH, 3'd0, 8'h3C);
    send(CMD_CALC, ALU_AND, 8'd0);
    wait_result();
    if (result !== 8'h30) begin
      $display("FAIL and_op: result=%h required 30", result);
      n_err++;
    end
    n_vec++;
    send(CMD_PUSH, 3'd0, 8'h0F);
    send(CMD_CALC, ALU_OR, 8'd0);
    wait_result();
    if (result !== 8'h3F || count !== 4'd1) begin
      $display("FAIL or_op: result=%h count=%0d required 3f 1", result, count);
      n_err++;
    end
    n_vec++;
    send(CMD_PUSH, 3'd0, 8'd3);
    send(CMD_CALC, ALU_SHL, 8'd0);
    wait_result();
    if (result !== 8'hF8) begin
      $display("FAIL shl_op: result=%h required f8", result);
      n_err++;
    end
    n_vec++;
    send(CMD_PUSH, 3'd0, 8'd11);
    send(CMD_CALC, ALU_SHR, 8'd0);
    wait_result();
    if (result !== 8'h1F || count !== 4'd1) begin
      $display("FAIL shr_op: result=%h count=%0d required 1f 1", result, count);
      n_err++;
    end
    n_vec++;
    send(CMD_CALC, ALU_ADD, 8'd0);
    if (err !== 1'b1 || count !== 4'd1 || cmd_ready !== 1'b1 || result !== 8'h1F) begin
      $display("FAIL calc_short: err=%0b count=%0d ready=%0b result=%h required 1 1 1 1f", err, count, cmd_ready, result);
      n_err++;
    end
    n_vec++;
    send(CMD_NOP, 3'd0, 8'd0);
    if (err !== 1'b0 || result_valid !== 1'b0 || count !== 4'd1) begin
      $display("FAIL nop: err=%0b rv=%0b count=%0d required 0 0 1", err, result_valid, count);
      n_err++;
    end
    n_vec++;
    send(CMD_POP, 3'd0, 8'd0);
  endtask

  task automatic test_mul();
    send(CMD_PUSH, 3'd0, 8'd3);
    send(CMD_PUSH, 3'd0, 8'd5);
    send(CMD_CALC, ALU_MUL, 8'd0);
`ifdef QUEUE_CALC_MUL_EN
    wait_result();
    if (result !== 8'd15 || count !== 4'd1) begin
      $display("FAIL mul_on: result=%0d count=%0d required 15 1", result, count);
      n_err++;
    end
    n_vec++;
    send(CMD_POP, 3'd0, 8'd0);
`else
    if (err !== 1'b1 || count !== 4'd2 || cmd_ready !== 1'b1) begin
      $display("FAIL mul_off: err=%0b count=%0d ready=%0b required 1 2 1", err, count, cmd_ready);
      n_err++;
    end
    n_vec++;
    send(CMD_POP, 3'd0, 8'd0);
    if (result !== 8'd3) begin
      $display("FAIL mul_off_q0: result=%0d required 3", result);
      n_err++;
    end
    n_vec++;
    send(CMD_POP, 3'd0, 8'd0);
    if (result !== 8'd5) begin
      $display("FAIL mul_off_q1: result=%0d required 5", result);
      n_err++;
    end
    n_vec++;
`endif
  endtask

  task automatic test_reset_abort();
    send(CMD_PUSH, 3'd0, 8'd7);
    send(CMD_PUSH, 3'd0, 8'd2);
    send(CMD_CALC, ALU_ADD, 8'd0);
    rst = 1'b1;
    #1;
    if ({count, empty, cmd_ready, result, result_valid, carry, err, state_dbg} !==
        {4'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      $display("FAIL abort_values: count=%0d empty=%0b ready=%0b result=%h rv=%0b carry=%0b err=%0b st=%0d required 0 1 1 00 0 0 0 0",
               count, empty, cmd_ready, result, result_valid, carry, err, state_dbg);
      n_err++;
    end
    n_vec++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b0 || count !== 4'd0) begin
        $display("FAIL abort_quiet: rv=%0b count=%0d required 0 0", result_valid, count);
        n_err++;
      end
      n_vec++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    send(CMD_POP, 3'd0, 8'd0);
    if (err !== 1'b1) begin
      $display("FAIL abort_empty: err=%0b required 1", err);
      n_err++;
    end
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_push();
    test_calc_sub();
    test_add_carry();
    test_full();
    test_logic_shift();
    test_mul();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: sim_time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
